// File: rtl/datamover_arb_pkg.sv
// Shared types and helpers for the datamover write-path arbiter.
package datamover_arb_pkg;

    localparam int unsigned BEAT_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        DONE
    } arb_state_t;

    // Number of data beats needed to carry len bytes (rounded up).
    function automatic logic [31:0] beats_of(input logic [31:0] len);
        return (len / BEAT_BYTES) + (((len % BEAT_BYTES) != 32'd0) ? 32'd1 : 32'd0);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_rr_ptr wins.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_id
);

    logic [ID_W-1:0] idx;
    logic            found;

    // Scan requesters starting at the pointer, wrapping around once.
    always_comb begin
        o_grant    = '0;
        o_grant_id = '0;
        idx        = '0;
        found      = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((32'(i_rr_ptr) + i) % NUM_REQ);
            if (!found && i_req[idx]) begin
                found        = 1'b1;
                o_grant[idx] = 1'b1;
                o_grant_id   = idx;
            end
        end
    end

endmodule

// File: rtl/datamover_wr_arbiter.sv
// Shares one datamover S2MM write path between NUM_REQ requesters, round-robin.
module datamover_wr_arbiter
    import datamover_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LEN_W   = 23,
    parameter int unsigned DATA_W  = 64,
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  i_req_length,
    input  logic [NUM_REQ-1:0]        i_req,
    output logic [NUM_REQ-1:0]        o_req_ack,
    input  logic [NUM_REQ-1:0]        i_wr_valid,
    input  logic [NUM_REQ*DATA_W-1:0] i_wr_data,
    output logic [NUM_REQ-1:0]        o_wr_ready,
    output logic [NUM_REQ-1:0]        o_wr_finish,
    output logic [ADDR_W-1:0]         o_dm_cmd_addr,
    output logic [LEN_W-1:0]          o_dm_cmd_length,
    output logic                      o_dm_cmd_req,
    input  logic                      i_dm_cmd_ack,
    output logic                      o_dm_wr_valid,
    output logic [DATA_W-1:0]         o_dm_wr_data,
    input  logic                      i_dm_wr_ready,
    input  logic                      i_dm_write_finish,
    output logic                      o_busy,
    output logic [ID_W-1:0]           o_grant_id,
    output logic                      o_err
);

    arb_state_t         state_q, state_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   beats_q, beats_d;
    logic               err_q, err_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    arb_id;
    logic [ADDR_W-1:0]  sel_addr;
    logic [LEN_W-1:0]   sel_len;
    logic               data_phase;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req      (i_req),
        .i_rr_ptr   (rr_ptr_q),
        .o_grant    (arb_grant),
        .o_grant_id (arb_id)
    );

    assign sel_addr        = i_req_addr[arb_id*ADDR_W +: ADDR_W];
    assign sel_len         = i_req_length[arb_id*LEN_W +: LEN_W];
    assign data_phase      = (state_q == DATA) && (beats_q != '0);
    assign o_dm_cmd_req    = (state_q == CMD);
    assign o_busy          = (state_q != IDLE);
    assign o_grant_id      = grant_q;
    assign o_dm_cmd_addr   = addr_q;
    assign o_dm_cmd_length = len_q;
    assign o_err           = err_q;

    // Route handshakes and data between the granted requester and the datamover.
    always_comb begin
        o_req_ack     = '0;
        o_wr_ready    = '0;
        o_wr_finish   = '0;
        o_dm_wr_valid = i_wr_valid[grant_q] & data_phase;
        o_dm_wr_data  = '0;
        if (state_q == CMD) begin
            o_req_ack[grant_q] = i_dm_cmd_ack;
        end
        if (data_phase) begin
            o_wr_ready[grant_q] = i_dm_wr_ready;
        end
        if (state_q == DATA) begin
            o_dm_wr_data = i_wr_data[grant_q*DATA_W +: DATA_W];
        end
        if (state_q == DONE) begin
            o_wr_finish[grant_q] = 1'b1;
        end
    end

    // Next-state logic: grant, command, data, completion.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        addr_d   = addr_q;
        len_d    = len_q;
        beats_d  = beats_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|arb_grant) begin
                    grant_d = arb_id;
                    addr_d  = sel_addr;
                    len_d   = sel_len;
                    beats_d = LEN_W'(beats_of(32'(sel_len)));
                    state_d = CMD;
                end
            end
            CMD: begin
                if (i_dm_cmd_ack) begin
                    state_d = (beats_q == '0) ? DONE : DATA;
                end
            end
            DATA: begin
                if (o_dm_wr_valid && i_dm_wr_ready) begin
                    beats_d = beats_q - 1'b1;
                end
                // A beat accepted in the same cycle as finish counts as delivered.
                if (i_dm_write_finish) begin
                    state_d = DONE;
                    err_d   = (beats_d != '0);
                end
            end
            DONE: begin
                rr_ptr_d = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            beats_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            beats_q  <= beats_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_datamover_wr_arbiter.sv
// Directed scoreboard bench for datamover_wr_arbiter (4 requesters).
module tb_datamover_wr_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int LW = 23;
    localparam int DW = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*AW-1:0]  i_req_addr;
    logic [NR*LW-1:0]  i_req_length;
    logic [NR-1:0]     i_req;
    logic [NR-1:0]     o_req_ack;
    logic [NR-1:0]     i_wr_valid;
    logic [NR*DW-1:0]  i_wr_data;
    logic [NR-1:0]     o_wr_ready;
    logic [NR-1:0]     o_wr_finish;
    logic [AW-1:0]     o_dm_cmd_addr;
    logic [LW-1:0]     o_dm_cmd_length;
    logic              o_dm_cmd_req;
    logic              i_dm_cmd_ack;
    logic              o_dm_wr_valid;
    logic [DW-1:0]     o_dm_wr_data;
    logic              i_dm_wr_ready;
    logic              i_dm_write_finish;
    logic              o_busy;
    logic [1:0]        o_grant_id;
    logic              o_err;

    typedef struct {
        int          id;
        logic [31:0] addr;
        logic [22:0] len;
    } cmd_t;

    cmd_t        cmd_q[$];
    logic [63:0] data_q[$];
    int          fin_q[$];

    int checks = 0;
    int errors = 0;

    datamover_wr_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .LEN_W   (LW),
        .DATA_W  (DW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_req_addr        (i_req_addr),
        .i_req_length      (i_req_length),
        .i_req             (i_req),
        .o_req_ack         (o_req_ack),
        .i_wr_valid        (i_wr_valid),
        .i_wr_data         (i_wr_data),
        .o_wr_ready        (o_wr_ready),
        .o_wr_finish       (o_wr_finish),
        .o_dm_cmd_addr     (o_dm_cmd_addr),
        .o_dm_cmd_length   (o_dm_cmd_length),
        .o_dm_cmd_req      (o_dm_cmd_req),
        .i_dm_cmd_ack      (i_dm_cmd_ack),
        .o_dm_wr_valid     (o_dm_wr_valid),
        .o_dm_wr_data      (o_dm_wr_data),
        .i_dm_wr_ready     (i_dm_wr_ready),
        .i_dm_write_finish (i_dm_write_finish),
        .o_busy            (o_busy),
        .o_grant_id        (o_grant_id),
        .o_err             (o_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge (input drive point).
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic post_req(input int g, input logic [31:0] addr, input logic [22:0] len);
        i_req_addr[g*AW +: AW]   = addr;
        i_req_length[g*LW +: LW] = len;
        i_req[g]                 = 1'b1;
    endtask

    // Act as the datamover for one grant expected to go to requester g.
    // send_beats < 0: requester offers every beat plus extras; otherwise only that many.
    task automatic serve(input int g, input logic [31:0] addr, input logic [22:0] len,
                         input int send_beats);
        int          nb;
        int          to_send;
        int          sent;
        int          post;
        bit          seen;
        bit          rdy;
        bit          offer;
        cmd_t        e;
        logic [3:0]  m;
        logic [63:0] payload[$];

        m       = 4'b0001 << g;
        nb      = (int'(len) + 7) / 8;
        to_send = (send_beats < 0) ? nb : send_beats;
        cmd_q.push_back('{id: g, addr: addr, len: len});
        fin_q.push_back(g);
        for (int k = 0; k < nb; k++) begin
            payload.push_back({addr, 16'(g), 16'(k)});
            if (k < to_send) data_q.push_back({addr, 16'(g), 16'(k)});
        end

        seen = 1'b0;
        for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
            tick();
            #2;
            if (o_dm_cmd_req) seen = 1'b1;
        end
        if (!seen) begin
            check("cmd_timeout", 64'd0, 64'd1);
            cmd_q.delete();
            data_q.delete();
            fin_q.delete();
            return;
        end

        e = cmd_q.pop_front();
        check("grant_id", 64'(o_grant_id), 64'(e.id));
        check("cmd_addr", 64'(o_dm_cmd_addr), 64'(e.addr));
        check("cmd_len", 64'(o_dm_cmd_length), 64'(e.len));
        check("busy_cmd", 64'(o_busy), 64'd1);

        i_dm_cmd_ack = 1'b1;
        #2;
        check("req_ack", 64'(o_req_ack), 64'(m));
        tick();
        i_dm_cmd_ack = 1'b0;
        i_req[g]     = 1'b0;

        if (nb == 0) begin
            #2;
            check("cmd_req_drop", 64'(o_dm_cmd_req), 64'd0);
            check("zl_valid", 64'(o_dm_wr_valid), 64'd0);
            check("zl_finish", 64'(o_wr_finish), 64'(4'b0001 << fin_q.pop_front()));
            check("zl_err", 64'(o_err), 64'd0);
            tick();
            #2;
            check("zl_finish_end", 64'(o_wr_finish), 64'd0);
            return;
        end

        sent = 0;
        post = 0;
        for (int cyc = 0; cyc < 3*nb + 10 && post < 3; cyc++) begin
            rdy   = (cyc % 3) != 2;
            offer = (sent < to_send) || (to_send == nb);
            for (int s = 0; s < NR; s++) i_wr_data[s*DW +: DW] = {$urandom, $urandom};
            if (sent < nb) i_wr_data[g*DW +: DW] = payload[sent];
            i_wr_valid    = offer ? '1 : '0;
            i_dm_wr_ready = rdy;
            #2;
            if (cyc == 0) check("cmd_req_drop", 64'(o_dm_cmd_req), 64'd0);
            check("dm_valid", 64'(o_dm_wr_valid), 64'(offer && (sent < nb)));
            check("wr_ready", 64'(o_wr_ready), (sent < nb && rdy) ? 64'(m) : 64'd0);
            if (o_dm_wr_valid && rdy) begin
                if (data_q.size() == 0) check("extra_beat", 64'd1, 64'd0);
                else check("wr_data", o_dm_wr_data, data_q.pop_front());
                sent++;
            end
            if (sent >= to_send) post++;
            tick();
        end
        check("beat_count", 64'(sent), 64'(to_send));

        i_wr_valid        = '0;
        i_dm_wr_ready     = 1'b0;
        i_dm_write_finish = 1'b1;
        #2;
        check("finish_wait", 64'(o_wr_finish), 64'd0);
        tick();
        i_dm_write_finish = 1'b0;
        #2;
        check("wr_finish", 64'(o_wr_finish), 64'(4'b0001 << fin_q.pop_front()));
        check("err", 64'(o_err), (to_send < nb) ? 64'd1 : 64'd0);
        check("busy_done", 64'(o_busy), 64'd1);
        tick();
        #2;
        check("finish_end", 64'(o_wr_finish), 64'd0);
        check("busy_idle", 64'(o_busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst               = 1'b1;
        i_req_addr        = '0;
        i_req_length      = '0;
        i_req             = '0;
        i_wr_valid        = '0;
        i_wr_data         = '0;
        i_dm_cmd_ack      = 1'b0;
        i_dm_wr_ready     = 1'b0;
        i_dm_write_finish = 1'b0;
        repeat (3) tick();
        #2;
        check("rst_ctrl", 64'({o_req_ack, o_wr_ready, o_wr_finish, o_dm_cmd_req,
                               o_dm_wr_valid, o_busy, o_err, o_grant_id}), 64'd0);
        check("rst_cmd", 64'({o_dm_cmd_addr, o_dm_cmd_length}), 64'd0);
        check("rst_data", o_dm_wr_data, 64'd0);
        tick();
        rst = 1'b0;

        // All four request together: served 0,1,2,3.
        for (int g = 0; g < NR; g++) post_req(g, 32'h1000 + 32'(g) * 32'h100, 23'd9);
        for (int g = 0; g < NR; g++) serve(g, 32'h1000 + 32'(g) * 32'h100, 23'd9, -1);

        // Pointer back at 0: requester 0 beats requester 3.
        post_req(3, 32'h1800, 23'd8);
        post_req(0, 32'h1900, 23'd8);
        serve(0, 32'h1900, 23'd8, -1);
        serve(3, 32'h1800, 23'd8, -1);

        // Single requester 0, addr 8, length 16.
        post_req(0, 32'd8, 23'd16);
        serve(0, 32'd8, 23'd16, -1);

        // Requester 2 then 1 and 3 together: 3 wins first.
        post_req(2, 32'h2000, 23'd8);
        serve(2, 32'h2000, 23'd8, -1);
        post_req(1, 32'h2100, 23'd12);
        post_req(3, 32'h2200, 23'd20);
        serve(3, 32'h2200, 23'd20, -1);
        serve(1, 32'h2100, 23'd12, -1);

        // Zero-length command.
        post_req(0, 32'h3000, 23'd0);
        serve(0, 32'h3000, 23'd0, -1);

        // Finish with two beats still outstanding.
        post_req(2, 32'h4000, 23'd24);
        serve(2, 32'h4000, 23'd24, 1);

        // Length sweep on requester 1 with extra beats offered.
        for (int len = 1; len <= 32; len++) begin
            post_req(1, 32'h5000 + 32'(len) * 32'h40, 23'(len));
            serve(1, 32'h5000 + 32'(len) * 32'h40, 23'(len), -1);
        end

        // Stray finish in IDLE does nothing.
        i_dm_write_finish = 1'b1;
        tick();
        i_dm_write_finish = 1'b0;
        #2;
        check("stray_finish", 64'({o_wr_finish, o_busy, o_err}), 64'd0);

        // Reset in DATA with 3 beats left.
        post_req(1, 32'h6000, 23'd24);
        tick();
        #2;
        check("rst_test_cmd", 64'(o_dm_cmd_req), 64'd1);
        i_dm_cmd_ack = 1'b1;
        tick();
        i_dm_cmd_ack  = 1'b0;
        i_req[1]      = 1'b0;
        i_wr_valid    = '1;
        i_dm_wr_ready = 1'b0;
        #1;
        check("pre_rst_busy", 64'(o_busy), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_ctrl", 64'({o_req_ack, o_wr_ready, o_wr_finish, o_dm_cmd_req,
                                   o_dm_wr_valid, o_busy, o_err, o_grant_id}), 64'd0);
        check("mid_rst_cmd", 64'({o_dm_cmd_addr, o_dm_cmd_length}), 64'd0);
        check("mid_rst_data", o_dm_wr_data, 64'd0);
        i_wr_valid = '0;
        tick();
        #2;
        check("rst_no_finish", 64'(o_wr_finish), 64'd0);
        tick();
        rst = 1'b0;

        // After reset the pointer is 0 again: 1 wins over 3.
        post_req(3, 32'h7000, 23'd16);
        post_req(1, 32'h7100, 23'd17);
        serve(1, 32'h7100, 23'd17, -1);
        serve(3, 32'h7000, 23'd16, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
